// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC, Count/Compare timer,
// external interrupt synchroniser and the pending-interrupt request.
module cp0_regfile #(
   parameter logic [31:0] PRID     = 32'h0000_0001,
   parameter bit          TIMER_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        int_i,
   input  logic        CauseEPCWrite_i,
   input  logic [1:0]  Cause_i,
   input  logic [1:0]  EPCOp_i,
   input  logic        RETOp_i,
   input  logic        CRFWrite_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] NPC_id_i,
   input  logic [31:0] NPC_ex_i,
   input  logic [31:0] PC_int_i,
   output logic [31:0] rdata_o,
   output logic [31:0] Status_o,
   output logic [31:0] Cause_o,
   output logic [31:0] EPC_o,
   output logic        INT_o
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   logic        status_ie;
   logic        status_pie;
   logic [7:0]  status_im;
   logic [4:0]  exc_code;
   logic        ip2;
   logic        ip7;
   logic [31:0] epc;
   logic [31:0] count;
   logic [31:0] compare;
   logic        int_sync1;
   logic        int_sync2;

   logic [4:0]  exc_code_nxt;
   logic [31:0] epc_nxt;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_epc;

   always_comb begin
      exc_code_nxt = 5'd0;
      case (Cause_i)
         2'b00: exc_code_nxt = 5'd0;
         2'b01: exc_code_nxt = 5'd8;
         2'b10: exc_code_nxt = 5'd10;
         2'b11: exc_code_nxt = 5'd12;
         default: exc_code_nxt = 5'd0;
      endcase
   end

   always_comb begin
      epc_nxt = epc;
      case (EPCOp_i)
         2'b00: epc_nxt = NPC_id_i;
         2'b01: epc_nxt = NPC_ex_i;
         2'b10: epc_nxt = PC_int_i;
         default: epc_nxt = epc;
      endcase
   end

   assign wr_count   = CRFWrite_i && (rd_i == REG_COUNT);
   assign wr_compare = CRFWrite_i && (rd_i == REG_COMPARE);
   assign wr_status  = CRFWrite_i && (rd_i == REG_STATUS);
   assign wr_epc     = CRFWrite_i && (rd_i == REG_EPC);

   always_ff @(posedge clk) begin
      if (rst) begin
         status_ie  <= 1'b0;
         status_pie <= 1'b0;
         status_im  <= 8'd0;
         exc_code   <= 5'd0;
         ip2        <= 1'b0;
         ip7        <= 1'b0;
         epc        <= 32'd0;
         count      <= 32'd0;
         compare    <= 32'd0;
         int_sync1  <= 1'b0;
         int_sync2  <= 1'b0;
      end else begin
         int_sync1 <= int_i;
         int_sync2 <= int_sync1;
         ip2       <= int_sync2;

         // Count/Compare are outside the exception priority chain.
         if (TIMER_EN) begin
            count <= wr_count ? wdata_i : count + 32'd1;
            if (wr_compare)
               ip7 <= 1'b0;
            else if (count == compare)
               ip7 <= 1'b1;
         end else begin
            count <= 32'd0;
            ip7   <= 1'b0;
         end
         if (wr_compare)
            compare <= wdata_i;

         if (CauseEPCWrite_i) begin
            status_pie <= status_ie;
            status_ie  <= 1'b0;
            exc_code   <= exc_code_nxt;
            epc        <= epc_nxt;
         end else if (RETOp_i) begin
            status_ie <= status_pie;
         end else begin
            if (wr_status) begin
               status_im  <= wdata_i[15:8];
               status_pie <= wdata_i[1];
               status_ie  <= wdata_i[0];
            end
            if (wr_epc)
               epc <= wdata_i;
         end
      end
   end

   assign Status_o = {16'd0, status_im, 6'd0, status_pie, status_ie};
   assign Cause_o  = {16'd0, ip7, 4'd0, ip2, 3'd0, exc_code, 2'd0};
   assign EPC_o    = epc;
   assign INT_o    = status_ie & ((ip2 & status_im[2]) | (ip7 & status_im[7]));

   always_comb begin
      rdata_o = 32'd0;
      case (rd_i)
         REG_COUNT:   rdata_o = count;
         REG_COMPARE: rdata_o = compare;
         REG_STATUS:  rdata_o = Status_o;
         REG_CAUSE:   rdata_o = Cause_o;
         REG_EPC:     rdata_o = epc;
         REG_PRID:    rdata_o = PRID;
         default:     rdata_o = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: word-level register model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cp0_regfile;

   localparam logic [31:0] PRID = 32'h0000_0001;

   logic        clk;
   logic        rst;
   logic        int_i;
   logic        CauseEPCWrite_i;
   logic [1:0]  Cause_i;
   logic [1:0]  EPCOp_i;
   logic        RETOp_i;
   logic        CRFWrite_i;
   logic [4:0]  rd_i;
   logic [31:0] wdata_i;
   logic [31:0] NPC_id_i;
   logic [31:0] NPC_ex_i;
   logic [31:0] PC_int_i;
   logic [31:0] rdata_o;
   logic [31:0] Status_o;
   logic [31:0] Cause_o;
   logic [31:0] EPC_o;
   logic        INT_o;

   int n_tests;
   int n_fail;

   cp0_regfile #(.PRID(PRID), .TIMER_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .int_i(int_i),
      .CauseEPCWrite_i(CauseEPCWrite_i), .Cause_i(Cause_i), .EPCOp_i(EPCOp_i),
      .RETOp_i(RETOp_i), .CRFWrite_i(CRFWrite_i), .rd_i(rd_i), .wdata_i(wdata_i),
      .NPC_id_i(NPC_id_i), .NPC_ex_i(NPC_ex_i), .PC_int_i(PC_int_i),
      .rdata_o(rdata_o), .Status_o(Status_o), .Cause_o(Cause_o), .EPC_o(EPC_o),
      .INT_o(INT_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: whole 32-bit words, updated from the architectural rules.
   logic [31:0] m_reg [0:31];
   logic [2:0]  m_int_hist;   // int_i samples, oldest in bit 2
   bit          m_valid;

   always @(posedge clk) begin
      logic [31:0] st, ca, ep, cnt, cmp;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         m_int_hist = 3'b000;
         m_valid    = 1'b1;
      end else if (m_valid) begin
         st = m_reg[12]; ca = m_reg[13]; ep = m_reg[14];
         cnt = m_reg[9]; cmp = m_reg[11];
         ca[10] = m_int_hist[1];
         m_int_hist = {m_int_hist[1:0], int_i};
         if (m_reg[9] == m_reg[11]) ca[15] = 1'b1;
         cnt = m_reg[9] + 32'd1;
         if (CRFWrite_i && rd_i == 5'd9) cnt = wdata_i;
         if (CRFWrite_i && rd_i == 5'd11) begin
            cmp = wdata_i;
            ca[15] = 1'b0;
         end
         if (CauseEPCWrite_i) begin
            st[1] = m_reg[12][0];
            st[0] = 1'b0;
            ca[6:2] = (Cause_i == 2'd0) ? 5'd0 : (Cause_i == 2'd1) ? 5'd8 :
                      (Cause_i == 2'd2) ? 5'd10 : 5'd12;
            if (EPCOp_i == 2'd0) ep = NPC_id_i;
            else if (EPCOp_i == 2'd1) ep = NPC_ex_i;
            else if (EPCOp_i == 2'd2) ep = PC_int_i;
         end else if (RETOp_i) begin
            st[0] = m_reg[12][1];
         end else if (CRFWrite_i) begin
            if (rd_i == 5'd12) st = wdata_i & 32'h0000_FF03;
            if (rd_i == 5'd14) ep = wdata_i;
         end
         m_reg[9] = cnt; m_reg[11] = cmp; m_reg[12] = st;
         m_reg[13] = ca; m_reg[14] = ep;
      end
   end

   function automatic logic m_int();
      return m_reg[12][0] & ((m_reg[13][10] & m_reg[12][10]) |
                             (m_reg[13][15] & m_reg[12][15]));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd15) return PRID;
      if (idx == 5'd9 || (idx >= 5'd11 && idx <= 5'd14)) return m_reg[idx];
      return 32'd0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_status", Status_o, m_reg[12]);
         check("model_cause", Cause_o, m_reg[13]);
         check("model_epc", EPC_o, m_reg[14]);
         check("model_int", {31'd0, INT_o}, {31'd0, m_int()});
         check("model_rdata", rdata_o, m_read(rd_i));
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
      CRFWrite_i = 1'b1; rd_i = idx; wdata_i = val;
      tick();
      CRFWrite_i = 1'b0;
   endtask

   task automatic exc(input logic [1:0] kind, input logic [1:0] src);
      CauseEPCWrite_i = 1'b1; Cause_i = kind; EPCOp_i = src;
      tick();
      CauseEPCWrite_i = 1'b0; EPCOp_i = 2'b11;
   endtask

   task automatic rd_check(input string name, input logic [4:0] idx, input logic [31:0] exp);
      rd_i = idx;
      #1;
      check(name, rdata_o, exp);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; m_valid = 1'b0;
      rst = 1'b1; int_i = 1'b1;
      CauseEPCWrite_i = 1'b0; Cause_i = 2'd0; EPCOp_i = 2'b11;
      RETOp_i = 1'b0; CRFWrite_i = 1'b0; rd_i = 5'd15; wdata_i = 32'd0;
      NPC_id_i = 32'h0000_1000; NPC_ex_i = 32'h0000_2004; PC_int_i = 32'h0000_0040;

      tick(2);
      check("rst_status", Status_o, 32'd0);
      check("rst_cause", Cause_o, 32'd0);
      check("rst_epc", EPC_o, 32'd0);
      check("rst_int", {31'd0, INT_o}, 32'd0);
      rd_check("rst_prid", 5'd15, PRID);
      rd_check("rst_count", 5'd9, 32'd0);

      rst = 1'b0;
      tick(2);
      check("sync_edge2", {31'd0, Cause_o[10]}, 32'd0);
      tick();
      check("sync_edge3", {31'd0, Cause_o[10]}, 32'd1);

      int_i = 1'b0;
      tick(3);
      check("int_deassert", {31'd0, Cause_o[10]}, 32'd0);

      mtc0(5'd12, 32'h0000_0401);
      check("status_wr", Status_o, 32'h0000_0401);
      int_i = 1'b1;
      tick(2);
      check("extint_edge2", {31'd0, INT_o}, 32'd0);
      tick();
      check("extint_edge3", {31'd0, INT_o}, 32'd1);

      exc(2'b00, 2'b10);
      check("int_epc", EPC_o, 32'h0000_0040);
      check("int_status", Status_o, 32'h0000_0402);
      check("int_code", {27'd0, Cause_o[6:2]}, 32'd0);
      check("int_masked", {31'd0, INT_o}, 32'd0);

      RETOp_i = 1'b1;
      tick();
      RETOp_i = 1'b0;
      check("eret_status", Status_o, 32'h0000_0403);
      check("eret_int", {31'd0, INT_o}, 32'd1);

      mtc0(5'd11, 32'd5);
      check("cmp_clear", {31'd0, Cause_o[15]}, 32'd0);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      tick(4);
      rd_check("count_at5", 5'd9, 32'd5);
      check("timer_before", {31'd0, Cause_o[15]}, 32'd0);
      tick();
      check("timer_hit", {31'd0, Cause_o[15]}, 32'd1);
      check("timer_int", {31'd0, INT_o}, 32'd1);
      tick(3);
      check("timer_sticky", {31'd0, Cause_o[15]}, 32'd1);
      mtc0(5'd11, 32'd100);
      check("timer_clear", {31'd0, Cause_o[15]}, 32'd0);
      check("timer_int_off", {31'd0, INT_o}, 32'd0);

      exc(2'b01, 2'b00);
      check("sys_epc", EPC_o, 32'h0000_1000);
      check("sys_code", {27'd0, Cause_o[6:2]}, 32'd8);
      check("sys_status", Status_o, 32'h0000_8002);
      exc(2'b11, 2'b01);
      check("ov_epc", EPC_o, 32'h0000_2004);
      check("ov_code", {27'd0, Cause_o[6:2]}, 32'd12);
      check("nested_status", Status_o, 32'h0000_8000);

      mtc0(5'd12, 32'h0000_8001);
      CRFWrite_i = 1'b1; rd_i = 5'd12; wdata_i = 32'h0000_FFFF;
      exc(2'b10, 2'b11);
      CRFWrite_i = 1'b0;
      check("coll_status", Status_o, 32'h0000_8002);
      check("coll_code", {27'd0, Cause_o[6:2]}, 32'd10);
      check("coll_epc", EPC_o, 32'h0000_2004);

      CRFWrite_i = 1'b1; rd_i = 5'd11; wdata_i = 32'd77; RETOp_i = 1'b1;
      tick();
      CRFWrite_i = 1'b0; RETOp_i = 1'b0;
      check("eret_status2", Status_o, 32'h0000_8003);
      rd_check("lose_compare", 5'd11, 32'd77);

      rd_check("read_prid", 5'd15, PRID);
      rd_check("read_unmapped", 5'd3, 32'd0);
      mtc0(5'd3, 32'hDEAD_BEEF);
      rd_check("write_unmapped", 5'd3, 32'd0);
      mtc0(5'd13, 32'hFFFF_FFFF);
      check("cause_ro", Cause_o & 32'h0000_007C, 32'h0000_0028);

      CRFWrite_i = 1'b1; rd_i = 5'd14; wdata_i = 32'h0000_1234;
      #1;
      check("rd_prewrite", rdata_o, 32'h0000_2004);
      tick();
      CRFWrite_i = 1'b0;
      rd_check("rd_postwrite", 5'd14, 32'h0000_1234);

      mtc0(5'd12, 32'hFFFF_FFFF);
      check("status_mask", Status_o, 32'h0000_FF03);

      mtc0(5'd9, 32'hFFFF_FFFF);
      rd_check("count_max", 5'd9, 32'hFFFF_FFFF);
      tick();
      rd_check("count_wrap", 5'd9, 32'd0);

      tick(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the pipelined CPU with interrupt support.
- Consumes the exception/return/mtc0 command signals from the control unit: CauseEPCWrite, Cause code, EPCOp, RETOp, CRFWrite.
- Returns Status, EPC and Cause to the control unit, plus the mfc0 read data.
- Synchronises the external interrupt, runs a Count/Compare timer, and raises the pending-interrupt request that the control unit samples as INT.

Parameters:
- PRID, 32'h0000_0001, value returned on reads of register 15.
- TIMER_EN, 1, 1 enables Count increment and the timer interrupt; 0 holds Count and Cause[15] at 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- int_i  in  1  external interrupt, asynchronous level.
- CauseEPCWrite_i  in  1  exception entry strobe.
- Cause_i  in  2  exception kind: 00 INT, 01 Sys, 10 Unimpl, 11 Ov.
- EPCOp_i  in  2  EPC source select: 00 NPC_id_i, 01 NPC_ex_i, 10 PC_int_i, 11 hold.
- RETOp_i  in  1  eret strobe.
- CRFWrite_i  in  1  mtc0 strobe.
- rd_i  in  5  CP0 register index for mfc0/mtc0.
- wdata_i  in  32  mtc0 write data.
- NPC_id_i  in  32  EPC candidate for Sys/Unimpl.
- NPC_ex_i  in  32  EPC candidate for Ov.
- PC_int_i  in  32  EPC candidate for INT.
- rdata_o  out  32  mfc0 read data (combinational from rd_i).
- Status_o  out  32  Status register (reg 12).
- Cause_o  out  32  Cause register (reg 13).
- EPC_o  out  32  EPC register (reg 14).
- INT_o  out  1  pending, enabled interrupt request to the control unit.

Behaviour:
- Reset (rst=1 at the edge): Status, Cause, EPC, Count, Compare and both synchroniser flops all go to 0. Hence INT_o=0 and rdata_o=0 for every index except 15.
- Register map:
  - 9 Count.
  - 11 Compare.
  - 12 Status: bit0 IE, bit1 PIE, bits[15:8] IM; all other bits read 0.
  - 13 Cause: bits[6:2] ExcCode, bit10 IP2 (external), bit15 IP7 (timer); all other bits read 0.
  - 14 EPC.
  - 15 PRID.
  - All other indices read 0; writes to them are ignored.
- Write masks: Status writes only bits[15:8] and [1:0]. Cause is read-only to mtc0. EPC, Count and Compare are fully writable.
- External interrupt path: int_i passes through a 2-flop synchroniser; Cause[10] loads the second flop each cycle (level, not sticky).
  - int_i rising before edge k gives sync1=1 at k, sync2=1 at k+1, Cause[10]=1 at k+2.
  - Deassertion follows with the same 3-edge latency.
- Timer, every edge with TIMER_EN=1:
  - Count <= Count+1, wrapping 32'hFFFF_FFFF to 0.
  - If the pre-increment Count == Compare, Cause[15] <= 1 (sticky).
  - mtc0 to Count loads wdata_i instead of incrementing.
  - mtc0 to Compare loads Compare and clears Cause[15]; the clear wins over a same-edge match.
- INT_o = Status[0] & ((Cause[10] & Status[10]) | (Cause[15] & Status[15])). It is combinational from registered state only.
- Exception entry (CauseEPCWrite_i=1):
  - PIE <= IE, IE <= 0.
  - ExcCode <= 0 / 8 / 10 / 12 for Cause_i = 00 / 01 / 10 / 11.
  - EPC <= the source selected by EPCOp_i; 11 leaves EPC unchanged.
  - A nested synchronous exception with IE=0 still overwrites EPC and ExcCode, and PIE becomes 0.
- eret (RETOp_i=1, CauseEPCWrite_i=0): IE <= PIE; PIE is unchanged. EPC and Cause are unchanged.
- Priority on the same edge: CauseEPCWrite_i > RETOp_i > CRFWrite_i.
  - A losing mtc0 to Status/EPC is dropped.
  - A losing mtc0 to Count/Compare still takes effect (these are not touched by exception or eret).
- mfc0 read is combinational. A read of a register written at the same edge returns the pre-write value; the pipeline handles forwarding.
- Status_o, Cause_o and EPC_o always show the current register contents.

Test Plan:
- Reset: assert rst for 2 cycles with int_i=1 -> all outputs 0, INT_o=0. After release, Cause[10]=1 on the 3rd edge.
- Ext INT:
  - Stimulus: mtc0 Status=32'h0000_0401; raise int_i.
  - Expect: INT_o=1 on the 3rd edge.
  - Then pulse CauseEPCWrite with Cause=00, EPCOp=10, PC_int_i=32'h0000_0040.
  - Expect: EPC=32'h40, Status=32'h0402, ExcCode=0, INT_o=0.
- eret: from the previous state pulse RETOp_i -> Status=32'h0403; INT_o=1 if int_i is still high.
- Timer:
  - Stimulus: Compare=5, Count=0, Status=32'h8001.
  - Expect: Cause[15] set on the edge after Count=5; INT_o=1.
  - Then mtc0 Compare=100: expect Cause[15]=0.
- Sys/Ov EPC select:
  - Cause=01, EPCOp=00, NPC_id=32'h1000: expect EPC=32'h1000, ExcCode=8.
  - Cause=11, EPCOp=01, NPC_ex=32'h2004: expect EPC=32'h2004, ExcCode=12.
- Collision: CauseEPCWrite (Cause=10) and CRFWrite rd=12 wdata=32'hFFFF on the same edge -> Status[0]=0, IM unchanged, ExcCode=10.
- Reads: rd=15 returns PRID; rd=3 returns 0.
- Count wrap: mtc0 Count=32'hFFFF_FFFF -> Count=0 one edge later.
